// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multiplier.
// - pp_rows / rows_after / reduction_layers size the carry-save tree.
// - bw_const gives the Baugh-Wooley correction word for signed products.
// - half_add / full_add are the bit-level cells used by wallace_csa_row.
// - STAGE_S1/S2/S3 index the per-stage valid bits.
package wallace_pkg;

  localparam int unsigned STAGE_S1  = 0;
  localparam int unsigned STAGE_S2  = 1;
  localparam int unsigned STAGE_S3  = 2;
  localparam int unsigned MAX_WIDTH = 64;

  // Rows left after one 3:2 layer: each full group of three becomes two,
  // leftovers pass through.
  function automatic int unsigned pp_rows(input int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int unsigned rows_after(input int unsigned n, input int unsigned k);
    int unsigned r;
    r = n;
    for (int unsigned i = 0; i < k; i++) r = pp_rows(r);
    return r;
  endfunction

  // Number of 3:2 layers needed to bring n rows down to two.
  function automatic int unsigned reduction_layers(input int unsigned n);
    int unsigned r;
    int unsigned cnt;
    r   = n;
    cnt = 0;
    while (r > 2) begin
      r   = pp_rows(r);
      cnt = cnt + 1;
    end
    return cnt;
  endfunction

  // 2^w + 2^(2w-1): folds the negative weights of the complemented
  // sign-row/column terms back into a modulo-2^(2w) sum.
  function automatic logic [2*MAX_WIDTH-1:0] bw_const(input int unsigned w);
    logic [2*MAX_WIDTH-1:0] c;
    c          = '0;
    c[w]       = 1'b1;
    c[2*w-1]   = 1'b1;
    return c;
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    logic [1:0] h0;
    logic [1:0] h1;
    h0 = half_add(x, y);
    h1 = half_add(h0[0], z);
    return {h0[1] | h1[1], h1[0]};
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// One word-wide row of 3:2 compressors.
// Ports: a, b, c  - three BW-bit addend rows
//        sum      - bitwise sum row
//        carry    - carry row, already shifted left by one
// sum + carry == a + b + c modulo 2^BW; the carry out of the top bit is
// dropped because the multiplier's final result fits in BW bits.
module wallace_csa_row
  import wallace_pkg::*;
#(
  parameter int unsigned BW = 16
) (
  input  logic [BW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic [BW-1:0] c,
  output logic [BW-1:0] sum,
  output logic [BW-1:0] carry
);

  logic [BW-2:0] cy;

  for (genvar i = 0; i < BW - 1; i++) begin : g_fa
    assign {cy[i], sum[i]} = full_add(a[i], b[i], c[i]);
  end

  assign sum[BW-1] = a[BW-1] ^ b[BW-1] ^ c[BW-1];
  assign carry     = {cy, 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier with valid/ready handshakes.
// Ports: clk, rst (sync, active-high)
//        in_valid/in_ready, in1, in2   - operand pair input
//        out_valid/out_ready, out      - 2*WIDTH-bit product output
//        is_signed                     - only when SIGNED_MUL_EN is defined
// Optional build macro SIGNED_MUL_EN: adds is_signed and Baugh-Wooley
// two's-complement multiplication.
// STAGES=3: S1 = first half of the 3:2 layers, S2 = rest down to two rows,
// S3 = final carry-propagate add. STAGES=2 merges S2 and S3.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
`ifdef SIGNED_MUL_EN
  input  logic               is_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned BW = 2 * WIDTH;
`ifdef SIGNED_MUL_EN
  localparam int unsigned N0 = WIDTH + 1;
`else
  localparam int unsigned N0 = WIDTH;
`endif
  localparam int unsigned NL  = reduction_layers(N0);
  localparam int unsigned NLA = (NL + 1) / 2;
  localparam int unsigned NLB = NL - NLA;
  localparam int unsigned R1  = rows_after(N0, NLA);

  logic              stall;
  logic              adv;
  logic [STAGES-1:0] vld;
  logic [N0*BW-1:0]  pp;
  logic [R1*BW-1:0]  s1_rows;
  logic [BW-1:0]     prod_q;

  assign stall     = vld[STAGES-1] && !out_ready;
  assign adv       = !stall;
  assign in_ready  = !stall;
  assign out_valid = vld[STAGES-1];
  assign out       = prod_q;

  // Partial-product rows, each already aligned to its weight.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    logic [WIDTH-1:0] g;
`ifdef SIGNED_MUL_EN
    // Baugh-Wooley: invert the bits whose weight mixes exactly one sign bit.
    localparam logic [WIDTH-1:0] MASK = (i == WIDTH - 1) ?
      {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    assign g = (in1 & {WIDTH{in2[i]}}) ^ (MASK & {WIDTH{is_signed}});
`else
    assign g = in1 & {WIDTH{in2[i]}};
`endif
    assign pp[i*BW +: BW] = BW'(g) << i;
  end

`ifdef SIGNED_MUL_EN
  // Signedness only shapes the partial products, so it is fully absorbed
  // before S1 and needs no pipeline register of its own.
  assign pp[WIDTH*BW +: BW] = is_signed ? BW'(bw_const(WIDTH)) : '0;
`endif

  // Reduction layers feeding S1.
  for (genvar l = 0; l <= NLA; l++) begin : g_la
    localparam int unsigned NR = rows_after(N0, l);
    logic [NR*BW-1:0] v;
    if (l == 0) begin : g_src
      assign v = pp;
    end else begin : g_red
      localparam int unsigned NP = rows_after(N0, l - 1);
      localparam int unsigned NG = NP / 3;
      for (genvar g = 0; g < NG; g++) begin : g_csa
        wallace_csa_row #(.BW(BW)) u_csa (
          .a    (g_la[l-1].v[(3*g)*BW +: BW]),
          .b    (g_la[l-1].v[(3*g+1)*BW +: BW]),
          .c    (g_la[l-1].v[(3*g+2)*BW +: BW]),
          .sum  (v[(2*g)*BW +: BW]),
          .carry(v[(2*g+1)*BW +: BW])
        );
      end
      if (NP > 3 * NG) begin : g_pass
        assign v[NR*BW-1 : 2*NG*BW] = g_la[l-1].v[NP*BW-1 : 3*NG*BW];
      end
    end
  end

  // Remaining reduction layers, from the S1 registers down to two rows.
  for (genvar l = 0; l <= NLB; l++) begin : g_lb
    localparam int unsigned NR = rows_after(R1, l);
    logic [NR*BW-1:0] v;
    if (l == 0) begin : g_src
      assign v = s1_rows;
    end else begin : g_red
      localparam int unsigned NP = rows_after(R1, l - 1);
      localparam int unsigned NG = NP / 3;
      for (genvar g = 0; g < NG; g++) begin : g_csa
        wallace_csa_row #(.BW(BW)) u_csa (
          .a    (g_lb[l-1].v[(3*g)*BW +: BW]),
          .b    (g_lb[l-1].v[(3*g+1)*BW +: BW]),
          .c    (g_lb[l-1].v[(3*g+2)*BW +: BW]),
          .sum  (v[(2*g)*BW +: BW]),
          .carry(v[(2*g+1)*BW +: BW])
        );
      end
      if (NP > 3 * NG) begin : g_pass
        assign v[NR*BW-1 : 2*NG*BW] = g_lb[l-1].v[NP*BW-1 : 3*NG*BW];
      end
    end
  end

  // Valid bits shift with the data; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[STAGES-2:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_rows <= '0;
    end else if (adv) begin
      s1_rows <= g_la[NLA].v;
    end
  end

  if (STAGES == 3) begin : g_three
    logic [BW-1:0] s2_a;
    logic [BW-1:0] s2_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_a   <= '0;
        s2_b   <= '0;
        prod_q <= '0;
      end else if (adv) begin
        s2_a   <= g_lb[NLB].v[BW-1:0];
        s2_b   <= g_lb[NLB].v[2*BW-1:BW];
        prod_q <= s2_a + s2_b;
      end
    end
  end else begin : g_two
    always_ff @(posedge clk) begin
      if (rst) begin
        prod_q <= '0;
      end else if (adv) begin
        prod_q <= g_lb[NLB].v[BW-1:0] + g_lb[NLB].v[2*BW-1:BW];
      end
    end
  end

endmodule
